// File: rtl/vga_pkg.sv
// Shared definitions for the VGA line-fetch block.
//   fetch_state_e : line-fetch FSM states (IDLE / FETCH / DRAIN)
//   ST_*          : system state codes; only ST_SHOW enables fetch and display
//   rgb444_t      : 12-bit RGB444 pixel
//   clog2_min1    : $clog2 clamped to at least one bit for tiny parameters
package vga_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   localparam logic [7:0] ST_WAIT = 8'h01;
   localparam logic [7:0] ST_LOAD = 8'h02;
   localparam logic [7:0] ST_SHOW = 8'h03;

   typedef logic [11:0] rgb444_t;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/line_ram.sv
// Ping-pong line buffer: two banks of W RGB444 pixels.
//   clk            : clock for the write port
//   we/wbank/wcol  : write enable, bank and column
//   wdata          : pixel to write
//   rbank/rcol     : read bank and column (combinational read)
//   rdata          : pixel at {rbank, rcol}; 0 when rcol is past the row end
module line_ram
   import vga_pkg::*;
#(
   parameter int unsigned W  = 200,
   parameter int unsigned CW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic          wbank,
   input  logic [CW-1:0] wcol,
   input  rgb444_t       wdata,
   input  logic          rbank,
   input  logic [CW-1:0] rcol,
   output rgb444_t       rdata
);

   rgb444_t mem [2][W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wbank][wcol] <= wdata;
      end
   end

   // Out-of-row columns only occur outside the display window; keep them defined.
   assign rdata = (32'(rcol) < W) ? mem[rbank][rcol] : '0;

endmodule

// File: rtl/vga_line_fetch.sv
// Streams one image row per spram_rd_sig pulse from SPRAM into a ping-pong
// line buffer and drives RGB444 for a W x H image at (STARTCOL, STARTROW).
//   clk, rst              : pixel clock, synchronous active-high reset
//   state                 : system state, 8'h03 = show
//   spram_rd_sig          : per-line pulse requesting the next row
//   xpos, ypos            : display coordinates (unsigned, wrap in blanking)
//   spram_addr/rden/dout  : SPRAM read port, data one cycle after rden
//   VGA_R/G/B             : registered pixel colour
//   busy                  : fetch in progress
//   fetch_ovf             : sticky, pulse arrived while busy
// Optional build macro VGA_FETCH_BORDER_EN draws a one-pixel white frame
// just outside the image window.
module vga_line_fetch
   import vga_pkg::*;
#(
   parameter int unsigned W        = 200,
   parameter int unsigned H        = 150,
   parameter int unsigned STARTROW = 0,
   parameter int unsigned STARTCOL = 0,
   parameter int unsigned ADDR_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        state,
   input  logic              spram_rd_sig,
   input  logic [11:0]       xpos,
   input  logic [11:0]       ypos,
   output logic [ADDR_W-1:0] spram_addr,
   output logic              spram_rden,
   input  logic [15:0]       spram_dout,
   output logic [3:0]        VGA_R,
   output logic [3:0]        VGA_G,
   output logic [3:0]        VGA_B,
   output logic              busy,
   output logic              fetch_ovf
);

   localparam int unsigned CW = clog2_min1(W);
   localparam int unsigned RW = clog2_min1(H);

   fetch_state_e      fsm;
   logic [CW-1:0]     col;
   logic [CW-1:0]     col_d;
   logic [RW-1:0]     row_idx;
   logic [ADDR_W-1:0] base;
   logic              wr_vld;
   logic              show;

   logic [11:0] rel_x;
   logic [11:0] rel_y;
   logic        in_win;
   logic        on_border;
   rgb444_t     rd_pix;
   rgb444_t     rgb;

   logic unused_dout;
   assign unused_dout = ^spram_dout[15:12];

   assign show = (state == ST_SHOW);

   // Fetch FSM. SPRAM data lags rden by one cycle, so each returned word is
   // written at col_d; the DRAIN cycle catches the last word.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm        <= IDLE;
         col        <= '0;
         col_d      <= '0;
         row_idx    <= '0;
         base       <= '0;
         spram_addr <= '0;
         spram_rden <= 1'b0;
         busy       <= 1'b0;
         fetch_ovf  <= 1'b0;
         wr_vld     <= 1'b0;
      end else begin
         col_d  <= col;
         wr_vld <= spram_rden;
         if (spram_rd_sig && (fsm != IDLE)) begin
            fetch_ovf <= 1'b1;
         end
         if (!show) begin
            // Leaving show abandons any partial row and restarts at image row 0.
            fsm        <= IDLE;
            col        <= '0;
            row_idx    <= '0;
            base       <= '0;
            spram_rden <= 1'b0;
            busy       <= 1'b0;
            wr_vld     <= 1'b0;
         end else begin
            unique case (fsm)
               IDLE: begin
                  if (spram_rd_sig) begin
                     fsm        <= FETCH;
                     col        <= '0;
                     spram_rden <= 1'b1;
                     spram_addr <= base;
                     busy       <= 1'b1;
                  end
               end
               FETCH: begin
                  if (col == CW'(W - 1)) begin
                     fsm        <= DRAIN;
                     spram_rden <= 1'b0;
                  end else begin
                     col        <= col + 1'b1;
                     spram_addr <= base + ADDR_W'(col) + ADDR_W'(1);
                  end
               end
               DRAIN: begin
                  fsm  <= IDLE;
                  busy <= 1'b0;
                  if (row_idx == RW'(H - 1)) begin
                     row_idx <= '0;
                     base    <= '0;
                  end else begin
                     row_idx <= row_idx + 1'b1;
                     base    <= base + ADDR_W'(W);
                  end
               end
               default: fsm <= IDLE;
            endcase
         end
      end
   end

   line_ram #(
      .W  (W),
      .CW (CW)
   ) u_line_ram (
      .clk   (clk),
      .we    (wr_vld),
      .wbank (row_idx[0]),
      .wcol  (col_d),
      .wdata (spram_dout[11:0]),
      .rbank (rel_y[0]),
      .rcol  (rel_x[CW-1:0]),
      .rdata (rd_pix)
   );

   // Coordinates left of / above the image wrap to large values and fall out.
   assign rel_x  = xpos - 12'(STARTCOL);
   assign rel_y  = ypos - 12'(STARTROW);
   assign in_win = (rel_x < 12'(W)) && (rel_y < 12'(H));

`ifdef VGA_FETCH_BORDER_EN
   logic x_ext;
   logic y_ext;
   // Expanded rectangle is one pixel wider on each side; 12'hFFF is "-1".
   assign x_ext     = (rel_x <= 12'(W)) || (rel_x == 12'hFFF);
   assign y_ext     = (rel_y <= 12'(H)) || (rel_y == 12'hFFF);
   assign on_border = x_ext && y_ext && !in_win;
`else
   assign on_border = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         rgb <= '0;
      end else if (show && in_win) begin
         rgb <= rd_pix;
      end else if (show && on_border) begin
         rgb <= 12'hFFF;
      end else begin
         rgb <= '0;
      end
   end

   assign VGA_R = rgb[11:8];
   assign VGA_G = rgb[7:4];
   assign VGA_B = rgb[3:0];

endmodule

// File: tb/tb_vga_line_fetch.sv
module tb_vga_line_fetch;

   localparam int unsigned W  = 4;
   localparam int unsigned H  = 2;
   localparam int unsigned SC = 2;
   localparam int unsigned SR = 1;
   localparam int unsigned AW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    state;
   logic          rd_sig;
   logic [11:0]   xpos;
   logic [11:0]   ypos;
   logic [AW-1:0] spram_addr;
   logic          spram_rden;
   logic [15:0]   spram_dout;
   logic [3:0]    vga_r;
   logic [3:0]    vga_g;
   logic [3:0]    vga_b;
   logic          busy;
   logic          fetch_ovf;

   always #5 clk = ~clk;

   vga_line_fetch #(
      .W        (W),
      .H        (H),
      .STARTROW (SR),
      .STARTCOL (SC),
      .ADDR_W   (AW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .state        (state),
      .spram_rd_sig (rd_sig),
      .xpos         (xpos),
      .ypos         (ypos),
      .spram_addr   (spram_addr),
      .spram_rden   (spram_rden),
      .spram_dout   (spram_dout),
      .VGA_R        (vga_r),
      .VGA_G        (vga_g),
      .VGA_B        (vga_b),
      .busy         (busy),
      .fetch_ovf    (fetch_ovf)
   );

   // SPRAM contents are a fixed scramble of the address.
   function automatic logic [15:0] word(input logic [15:0] a);
      logic [15:0] t;
      t = a * 16'd173 + 16'h005A;
      return {4'h0, t[11:0]};
   endfunction

   always @(posedge clk) begin
      if (spram_rden) spram_dout <= word(spram_addr);
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference model: image rows held per bank, current image row.
   logic [11:0] lb [2][W];
   bit          lb_ok [2];
   int          mrow;
   bit          exp_ovf;

   typedef struct {
      bit          skip;
      logic [11:0] rgb;
   } pix_t;

   logic [15:0] addr_q [$];
   pix_t        pix_q [$];
   int          pix_ready = 0;
   bit          chk_busy = 1'b0;
   int          brun = 0;
   int          rrun = 0;

   // Address monitor
   always @(negedge clk) begin
      if (!rst && spram_rden) begin
         check("addr_expected", 32'(addr_q.size() > 0), 32'd1);
         if (addr_q.size() > 0) check("spram_addr", 32'(spram_addr), 32'(addr_q.pop_front()));
      end
   end

   // Pixel monitor: entries queued before an edge are due at the following negedge.
   always @(posedge clk) pix_ready = pix_q.size();
   always @(negedge clk) begin
      if (pix_ready > 0) begin
         pix_t p;
         p = pix_q.pop_front();
         pix_ready--;
         if (!p.skip) check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(p.rgb));
      end
   end

   // Busy / rden run-length monitor
   always @(negedge clk) begin
      if (busy) brun++;
      else begin
         if (brun > 0 && chk_busy) check("busy_len", 32'(brun), 32'(W + 1));
         brun = 0;
      end
      if (spram_rden) rrun++;
      else begin
         if (rrun > 0 && chk_busy) check("rden_len", 32'(rrun), 32'(W));
         rrun = 0;
      end
   end

   function automatic logic [11:0] exp_pix(input int x, input int y, input int st,
                                          output bit skip);
      int rx;
      int ry;
      skip = 1'b0;
      rx = (x - int'(SC)) & 12'hFFF;
      ry = (y - int'(SR)) & 12'hFFF;
      if (st != 3) return 12'h000;
      if (rx < int'(W) && ry < int'(H)) begin
         if (!lb_ok[ry % 2]) skip = 1'b1;
         return lb[ry % 2][rx];
      end
`ifdef VGA_FETCH_BORDER_EN
      if ((rx <= int'(W) || rx == 4095) && (ry <= int'(H) || ry == 4095)) return 12'hFFF;
`endif
      return 12'h000;
   endfunction

   task automatic disp(input int x, input int y, input int st);
      pix_t p;
      @(posedge clk); #1;
      xpos  = 12'(x);
      ypos  = 12'(y);
      state = 8'(st);
      rd_sig = 1'b0;
      if (st != 3) mrow = 0;
      p.rgb = exp_pix(x, y, st, p.skip);
      pix_q.push_back(p);
   endtask

   task automatic rand_disp(input int n, input bit mix_state);
      for (int i = 0; i < n; i++) begin
         int x;
         int y;
         int st;
         int r;
         r = $urandom_range(0, 9);
         x = (r < 7) ? $urandom_range(0, 8) : (r < 9) ? 4095 : $urandom_range(0, 4095);
         r = $urandom_range(0, 9);
         y = (r < 7) ? $urandom_range(0, 4) : (r < 9) ? 4095 : $urandom_range(0, 4095);
         st = (mix_state && $urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : 3;
         disp(x, y, st);
      end
   endtask

   task automatic do_fetch(input bit inject_ovf);
      int n;
      for (int c = 0; c < int'(W); c++) begin
         addr_q.push_back(16'(mrow * int'(W) + c));
         lb[mrow % 2][c] = word(16'(mrow * int'(W) + c)) & 16'h0FFF;
      end
      lb_ok[mrow % 2] = 1'b1;
      @(posedge clk); #1;
      check("rden_before_pulse", 32'(spram_rden), 32'd0);
      state  = 8'h03;
      rd_sig = 1'b1;
      @(posedge clk); #1;
      rd_sig = 1'b0;
      check("rden_after_pulse", 32'(spram_rden), 32'd1);
      if (inject_ovf) begin
         rd_sig = 1'b1;
         exp_ovf = 1'b1;
         @(posedge clk); #1;
         rd_sig = 1'b0;
      end
      n = 0;
      while (busy && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      check("busy_done", 32'(busy), 32'd0);
      check("fetch_ovf", 32'(fetch_ovf), 32'(exp_ovf));
      mrow = (mrow + 1) % int'(H);
   endtask

   initial begin
      rst = 1'b1; state = 8'h03; rd_sig = 1'b0; xpos = '0; ypos = '0;
      mrow = 0; exp_ovf = 1'b0; lb_ok[0] = 1'b0; lb_ok[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rden", 32'(spram_rden), 32'd0);
      check("rst_addr", 32'(spram_addr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovf", 32'(fetch_ovf), 32'd0);
      check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
      rst = 1'b0;
      chk_busy = 1'b1;

      // Pulse outside show state is ignored.
      state = 8'h01; rd_sig = 1'b1;
      @(posedge clk); #1; rd_sig = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("idle_pulse_busy", 32'(busy), 32'd0);
      state = 8'h03;

      // Rows 0, 1 then wrap back to row 0.
      do_fetch(1'b0);
      do_fetch(1'b0);
      do_fetch(1'b0);
      rand_disp(40, 1'b0);

      // Overflow pulse during fetch; sticky afterwards.
      do_fetch(1'b1);
      do_fetch(1'b0);
      rand_disp(20, 1'b0);

      // Abort at col 2 by leaving show state.
      chk_busy = 1'b0;
      state = 8'h03;
      for (int c = 0; c < int'(W); c++) addr_q.push_back(16'(mrow * int'(W) + c));
      @(posedge clk); #1;
      rd_sig = 1'b1;
      @(posedge clk); #1;
      rd_sig = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      state = 8'h02;
      @(posedge clk); #1;
      check("abort_rden", 32'(spram_rden), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      addr_q.delete();
      lb_ok[mrow % 2] = 1'b0;
      mrow = 0;
      disp(int'(SC), int'(SR), 2);
      disp(int'(SC) + 1, int'(SR) + 1, 2);
      repeat (2) @(posedge clk);
      #1;
      chk_busy = 1'b1;

      // Row index restarts at 0 after the abort.
      do_fetch(1'b0);
      do_fetch(1'b0);
      rand_disp(30, 1'b1);

      // Mixed random phase.
      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(0, 1) == 1) do_fetch($urandom_range(0, 3) == 0);
         else rand_disp(int'($urandom_range(3, 12)), 1'b1);
      end

      repeat (3) @(posedge clk);
      #1;
      check("pix_q_drained", 32'(pix_q.size()), 32'd0);
      check("ovf_sticky", 32'(fetch_ovf), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("ovf_cleared", 32'(fetch_ovf), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_line_fetch.md
# vga_line_fetch

Downstream companion of the VGA timing generator. On each per-line read pulse it streams one image row of `W` pixels out of the single-port SPRAM into a ping-pong line buffer. During the active display window it drives RGB444 for the `W`×`H` image placed at (`STARTCOL`, `STARTROW`) and black elsewhere. It is active only in display state 3.

## Interface
- `W`, 200: image width in pixels.
- `H`, 150: image height in rows.
- `STARTROW`, 0: display row (ypos) of image row 0.
- `STARTCOL`, 0: display column (xpos) of image column 0.
- `ADDR_W`, 16: SPRAM word-address width.
- `clk`  in  1: pixel clock; sole clock.
- `rst`  in  1: synchronous, active-high reset.
- `state`  in  8: system state; 8'h03 = show, anything else = idle.
- `spram_rd_sig`  in  1: one-cycle pulse from timing generator; fetch next row.
- `xpos`  in  12: display X, unsigned (blanking wraps to large values).
- `ypos`  in  12: display Y, unsigned.
- `spram_addr`  out  ADDR_W: SPRAM read address.
- `spram_rden`  out  1: SPRAM read enable.
- `spram_dout`  in  16: SPRAM read data; valid 1 cycle after `spram_rden`; bits [11:0] = RGB444.
- `VGA_R`, `VGA_G`, `VGA_B`  out  4 each: pixel colour.
- `busy`  out  1: fetch in progress.
- `fetch_ovf`  out  1: sticky; `spram_rd_sig` arrived while busy.

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- IDLE → FETCH on `spram_rd_sig` && `state`==8'h03. `col` clears to 0.
- FETCH issues `spram_rden`=1 and `spram_addr` = `base` + `col`, with `col` counting 0..W-1, one per cycle. After `col`==W-1 it moves to DRAIN.
- DRAIN lasts one cycle, capturing the final returned word.
- Each returned word is written at `col_d` (col delayed 1) into bank `row_idx[0]`.
- At the end of DRAIN:
  - `row_idx` increments and `base` += W.
  - If `row_idx` was H-1, both clear to 0 (frame wrap).
  - FSM returns to IDLE.
- `base` is a running accumulator; no multiplier is used.
- `spram_rd_sig` while in FETCH or DRAIN is ignored and sets `fetch_ovf`.
- Display path:
  - `in_win` = (`xpos`−`STARTCOL`) < W && (`ypos`−`STARTROW`) < H, using 12-bit unsigned subtraction, so values below the start wrap and fall outside the window.
  - Read address = `xpos`−`STARTCOL`; read bank = (`ypos`−`STARTROW`)[0].
  - Output is the buffered pixel when `in_win` && `state`==8'h03, else 12'h000.
- `state` ≠ 8'h03 forces FSM to IDLE, `spram_rden`=0, and clears `row_idx`, `base` and `col`. Any partial row is discarded.
- The bank written for image row r equals r[0], which is the bank displayed at image row r. The upstream pulse precedes the display row by one line, so write and read never hit the same bank.

## Timing
- Reset values:
  - FSM: IDLE.
  - `spram_addr`, `spram_rden`, `busy`, `fetch_ovf`: 0.
  - `VGA_R`, `VGA_G`, `VGA_B`: 0.
  - `row_idx`, `base`, `col`: 0.
- `spram_rden` rises the cycle after the `spram_rd_sig` pulse and stays high exactly W cycles.
- `busy` is high from the first FETCH cycle through DRAIN, i.e. W+1 cycles.
- A fetch must complete within one line: W+1 ≤ H_TOTAL of the timing generator.
- Display latency: RGB is registered, valid 1 cycle after the corresponding `xpos`/`ypos`. The line-buffer read is combinational or flow-through from the registered address within that cycle.
- `rst` mid-fetch: the next cycle is IDLE with `spram_rden`=0 and line-buffer contents undefined.

## Configuration
- `VGA_FETCH_BORDER_EN`:
  - Defined: pixels exactly one position outside the image window (column STARTCOL−1 or STARTCOL+W, row STARTROW−1 or STARTROW+H, within the expanded rectangle) output 12'hFFF white.
  - Undefined: these pixels are black like the rest of the background.
  - The border when `STARTCOL`/`STARTROW`=0 follows the same unsigned wrap, so the left/top edge is not drawn.

## Structure
- Shared package `vga_pkg`:
  - FSM enum (IDLE/FETCH/DRAIN).
  - State codes ST_WAIT=8'h01, ST_LOAD=8'h02, ST_SHOW=8'h03.
  - RGB444 pixel typedef.
- One sub-module, `line_ram`: simple dual-port 2×W×12 memory.
  - One write port, clocked.
  - One read port, bank bit + column.

## Test plan
- W=4, H=2, `state`=3, SPRAM word(a)=a: pulse `rd_sig` → `spram_addr` 0,1,2,3 on 4 consecutive cycles; `busy` 5 cycles; `row_idx`=1, `base`=4 after.
- Second pulse → addresses 4..7; afterwards `row_idx`=0, `base`=0 (wrap).
- After row 0 is loaded, STARTCOL=2, STARTROW=0, xpos 2..5 at ypos 0 → RGB 0,1,2,3 one cycle later; xpos 1 and 6 → 000.
- Pulse during FETCH → addresses unaffected, `fetch_ovf`=1 and it stays 1 until `rst`.
- `state` drops to 2 at `col`=2 → `spram_rden`=0 next cycle, FSM IDLE, `row_idx`=0, RGB 000.
- With `VGA_FETCH_BORDER_EN`, STARTCOL=2, STARTROW=1: xpos 1 at ypos 1 → FFF; without the macro → 000.
